fetch_unit: RTL

- Instruction fetch stage directly upstream of the direct-mapped cache. Drives the cache's processor-side bus.
- Issues line-aligned 64-byte read requests and collects the 8×64-bit response beats into a line buffer.
- Streams 32-bit instructions to decode over a valid/ready handshake.
- Handles branch redirects, including redirects that arrive while a bus transaction is in flight.

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 64-byte lines from the cache bus
// and streams 32-bit instructions to decode.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0,
  parameter int BEATS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      redirect,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [BUS_DATA_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(BEATS);
  localparam int LW = BEATS * BUS_DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
    {`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00};

  typedef enum logic [2:0] {
    INIT, REQ, ACK_WAIT, RESP, DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic                      flush_q, flush_d;
  logic [CW-1:0]             beat_q, beat_d;
  logic                      ack_q, ack_d;
  logic [LW-1:0]             line_q, line_d;

  logic [BUS_DATA_WIDTH-1:0] rpc;
  logic [8:0]                boff;
  logic [8:0]                woff;

  assign rpc  = redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign boff = {beat_q, 6'b0};
  assign woff = {pc_q[5:2], 5'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    line_d  = line_q;
    unique case (state_q)
      INIT: begin
        state_d = REQ;
        if (redirect) pc_d = rpc;
      end
      REQ: begin
        if (redirect) pc_d = rpc;
        if (bus_reqack) begin
          state_d = RESP;
          beat_d  = '0;
          if (redirect) flush_d = 1'b1;
        end
      end
      ACK_WAIT, RESP: begin
        if (state_q == ACK_WAIT) state_d = RESP;
        if (redirect) begin
          flush_d = 1'b1;
          pc_d    = rpc;
        end
        if (bus_respcyc) begin
          line_d[boff +: BUS_DATA_WIDTH] = bus_resp;
          ack_d = 1'b1;
        end
        // beat_cnt advances with the ack, not with the data
        if (ack_q) begin
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST) begin
            flush_d = 1'b0;
            state_d = (flush_q || redirect) ? REQ : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (instr_ready) begin
          pc_d = pc_q + BUS_DATA_WIDTH'(4);
          if (pc_q[5:2] == 4'hF) state_d = REQ;
        end
        if (redirect) begin
          pc_d    = rpc;
          state_d = REQ;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? {pc_q[BUS_DATA_WIDTH-1:6], 6'b0} : '0;
  assign bus_reqtag  = bus_reqcyc ? REQ_TAG : '0;
  assign bus_respack = ack_q;
  assign instr_valid = (state_q == DRAIN);
  assign instr       = instr_valid ? line_q[woff +: 32] : '0;
  assign instr_pc    = instr_valid ? pc_q : '0;

  a_beat_overlap: assert property (
    @(posedge clk) disable iff (!reset)
    !(ack_q && bus_respcyc));

  a_resp_tag: assert property (
    @(posedge clk) disable iff (!reset)
    bus_respcyc |-> bus_resptag == REQ_TAG);

endmodule
